// File: rtl/priority_controller_pkg.sv
// Shared types for execute-stage result arbitration: mux select codes, unit bit indices, index-to-select mapping.
package priority_controller_pkg;

  localparam int NUM_EXE_UNITS = 9;
  localparam int UNIT_IDX_W    = $clog2(NUM_EXE_UNITS);

  typedef enum logic [3:0] {
    DEFAULT_unit  = 4'd0,
    ALU_unit      = 4'd1,
    FP_unit       = 4'd2,
    MUL_unit      = 4'd3,
    DIV_unit      = 4'd4,
    FMUL_unit     = 4'd5,
    FDIV_unit     = 4'd6,
    FADD_SUB_unit = 4'd7,
    FSQRT_unit    = 4'd8,
    R4_unit       = 4'd9
  } priority_t;

  // Bit positions in unit_valid_i / grant_o / unit_stall_o; lower index means higher priority.
  typedef enum logic [UNIT_IDX_W-1:0] {
    FDIV_IDX     = 4'd0,
    FMUL_IDX     = 4'd1,
    FADD_SUB_IDX = 4'd2,
    DIV_IDX      = 4'd3,
    MUL_IDX      = 4'd4,
    FP_IDX       = 4'd5,
    ALU_IDX      = 4'd6,
    FSQRT_IDX    = 4'd7,
    R4_IDX       = 4'd8
  } unit_idx_e;

  function automatic priority_t idx2psel(input logic [UNIT_IDX_W-1:0] idx);
    priority_t p;
    p = DEFAULT_unit;
    case (unit_idx_e'(idx))
      FDIV_IDX:     p = FDIV_unit;
      FMUL_IDX:     p = FMUL_unit;
      FADD_SUB_IDX: p = FADD_SUB_unit;
      DIV_IDX:      p = DIV_unit;
      MUL_IDX:      p = MUL_unit;
      FP_IDX:       p = FP_unit;
      ALU_IDX:      p = ALU_unit;
      FSQRT_IDX:    p = FSQRT_unit;
      R4_IDX:       p = R4_unit;
      default:      p = DEFAULT_unit;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/priority_controller_age_counter.sv
// Saturating per-unit age counter; clr beats hold beats inc, saturated flag is a pure decode of the count.
// One-cycle update latency; hold freezes the count while the downstream register is not accepting.
module prio_age_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic hold,
  input  logic inc,
  output logic saturated
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] age;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age <= '0;
    end else if (clr) begin
      age <= '0;
    end else if (!hold && inc && !saturated) begin
      age <= age + 1'b1;
    end
  end

  assign saturated = (age == W'(LIMIT));

endmodule

// File: rtl/priority_controller.sv
// Fixed-priority arbiter over the nine execute producers with age-based promotion of starved units.
// Zero-cycle valid-to-select; on downstream stall every valid unit is held and ages freeze, flush kills all.
module priority_controller
  import priority_controller_pkg::*;
#(
  parameter int NUM_UNITS    = NUM_EXE_UNITS,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_UNITS-1:0] unit_valid_i,
  input  logic                 downstream_stall_i,
  input  logic                 flush_i,
  output priority_t            p_sel_o,
  output logic [NUM_UNITS-1:0] grant_o,
  output logic [NUM_UNITS-1:0] unit_stall_o
);

  logic [NUM_UNITS-1:0]  sat;
  logic [NUM_UNITS-1:0]  starving;
  logic [NUM_UNITS-1:0]  pick_set;
  logic [NUM_UNITS-1:0]  win_onehot;
  logic                  win_vld;
  logic [UNIT_IDX_W-1:0] win_idx;
  logic                  grant_vld;

  assign starving = unit_valid_i & sat;
  assign pick_set = (|starving) ? starving : unit_valid_i;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (pick_set[i]) begin
        win_vld = 1'b1;
        win_idx = UNIT_IDX_W'(i);
      end
    end
  end

  assign win_onehot = win_vld ? (NUM_UNITS'(1) << win_idx) : '0;
  assign grant_vld  = reset_n && win_vld && !downstream_stall_i && !flush_i;

  assign grant_o      = grant_vld ? win_onehot : '0;
  assign p_sel_o      = (!reset_n || flush_i || !win_vld) ? DEFAULT_unit : idx2psel(win_idx);
  // A stalled cycle has no grant, so this also holds every valid unit during downstream stall.
  assign unit_stall_o = (!reset_n || flush_i) ? '0 : (unit_valid_i & ~grant_o);

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_age
    prio_age_counter #(
      .LIMIT (STARVE_LIMIT)
    ) u_age (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (flush_i || !unit_valid_i[g] || grant_o[g]),
      .hold      (downstream_stall_i),
      .inc       (1'b1),
      .saturated (sat[g])
    );
  end

endmodule

// File: tb/tb_priority_controller.sv
// Directed scenarios plus constrained-random traffic checked against an age-array reference model.
module tb_priority_controller;
  import priority_controller_pkg::*;

  localparam int LIMIT = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] unit_valid_i;
  logic       downstream_stall_i;
  logic       flush_i;
  priority_t  p_sel_o;
  logic [8:0] grant_o;
  logic [8:0] unit_stall_o;

  priority_controller #(.STARVE_LIMIT(LIMIT)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .unit_valid_i       (unit_valid_i),
    .downstream_stall_i (downstream_stall_i),
    .flush_i            (flush_i),
    .p_sel_o            (p_sel_o),
    .grant_o            (grant_o),
    .unit_stall_o       (unit_stall_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  priority_t psel_tab [9] = '{FDIV_unit, FMUL_unit, FADD_SUB_unit, DIV_unit, MUL_unit,
                              FP_unit, ALU_unit, FSQRT_unit, R4_unit};

  int         age [9];
  priority_t  exp_ps;
  logic [8:0] exp_g, exp_us, prev_stall;
  priority_t  obs_ps;
  logic [8:0] obs_g, obs_us;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    int win = -1;
    for (int i = 0; i < 9; i++) if (win < 0 && unit_valid_i[i] && age[i] == LIMIT) win = i;
    for (int i = 0; i < 9; i++) if (win < 0 && unit_valid_i[i]) win = i;
    if (flush_i) begin
      exp_ps = DEFAULT_unit; exp_g = '0; exp_us = '0;
    end else begin
      exp_ps = (win < 0) ? DEFAULT_unit : psel_tab[win];
      exp_g  = (win >= 0 && !downstream_stall_i) ? (9'd1 << win) : 9'd0;
      exp_us = unit_valid_i & ~exp_g;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) age[i] = 0;
    prev_stall = '0;
  endtask

  // One cycle: predict, sample on the falling edge, advance the model on the rising edge.
  task automatic step();
    model_eval();
    @(negedge clk);
    obs_ps = p_sel_o; obs_g = grant_o; obs_us = unit_stall_o;
    chk("p_sel",   32'(obs_ps), 32'(exp_ps));
    chk("grant",   32'(obs_g),  32'(exp_g));
    chk("u_stall", 32'(obs_us), 32'(exp_us));
    chk("inv_onehot0", 32'($onehot0(obs_g)), 32'd1);
    chk("inv_g_and_s", 32'(obs_g & obs_us), 32'd0);
    chk("inv_subset",  32'(obs_g & ~unit_valid_i), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      if (flush_i || !unit_valid_i[i] || exp_g[i]) age[i] = 0;
      else if (!downstream_stall_i && age[i] < LIMIT) age[i]++;
    end
    prev_stall = exp_us;
    #1;
  endtask

  task automatic drive(input logic [8:0] v, input logic st, input logic fl);
    unit_valid_i = v; downstream_stall_i = st; flush_i = fl;
    step();
  endtask

  initial begin
    reset_n = 1'b0; unit_valid_i = 9'h041; downstream_stall_i = 1'b0; flush_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel",  32'(p_sel_o),      32'(DEFAULT_unit));
    chk("rst_grant", 32'(grant_o),      32'd0);
    chk("rst_stall", 32'(unit_stall_o), 32'd0);
    reset_n = 1'b1;

    // 1: idle after reset
    drive(9'h000, 1'b0, 1'b0);
    chk("t1_psel", 32'(obs_ps), 32'(DEFAULT_unit));
    chk("t1_grant", 32'(obs_g), 32'd0);

    // 2: contention, then ALU alone
    drive(9'h041, 1'b0, 1'b0);
    chk("t2_psel", 32'(obs_ps), 32'(FDIV_unit));
    chk("t2_grant", 32'(obs_g), 32'h001);
    chk("t2_stall", 32'(obs_us), 32'h040);
    drive(9'h040, 1'b0, 1'b0);
    chk("t2_alu_psel", 32'(obs_ps), 32'(ALU_unit));
    chk("t2_alu_grant", 32'(obs_g), 32'h040);

    // 3: starvation promotion of ALU
    for (int c = 0; c < LIMIT; c++) begin
      drive(9'h041, 1'b0, 1'b0);
      chk("t3_fdiv_grant", 32'(obs_g), 32'h001);
    end
    drive(9'h041, 1'b0, 1'b0);
    chk("t3_promo_psel", 32'(obs_ps), 32'(ALU_unit));
    chk("t3_promo_grant", 32'(obs_g), 32'h040);
    drive(9'h041, 1'b0, 1'b0);
    chk("t3_after_grant", 32'(obs_g), 32'h001);
    drive(9'h040, 1'b0, 1'b0);

    // 4: downstream stall on MUL
    for (int c = 0; c < 3; c++) begin
      drive(9'h010, 1'b1, 1'b0);
      chk("t4_psel", 32'(obs_ps), 32'(MUL_unit));
      chk("t4_grant", 32'(obs_g), 32'd0);
      chk("t4_stall", 32'(obs_us), 32'h010);
    end
    drive(9'h010, 1'b0, 1'b0);
    chk("t4_release", 32'(obs_g), 32'h010);

    // 5: flush with stall while ALU age is 5; ALU must then need a full LIMIT again
    for (int c = 0; c < 5; c++) drive(9'h041, 1'b0, 1'b0);
    drive(9'h041, 1'b1, 1'b1);
    chk("t5_psel", 32'(obs_ps), 32'(DEFAULT_unit));
    chk("t5_stall", 32'(obs_us), 32'd0);
    chk("t5_grant", 32'(obs_g), 32'd0);
    for (int c = 0; c < LIMIT; c++) begin
      drive(9'h041, 1'b0, 1'b0);
      chk("t5_fdiv_grant", 32'(obs_g), 32'h001);
    end
    drive(9'h041, 1'b0, 1'b0);
    chk("t5_promo", 32'(obs_g), 32'h040);

    // 6: async reset between edges while stalled with a well-aged ALU
    for (int c = 0; c < 6; c++) drive(9'h041, 1'b0, 1'b0);
    drive(9'h041, 1'b1, 1'b0);
    unit_valid_i = 9'h041; downstream_stall_i = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("t6_psel",  32'(p_sel_o),      32'(DEFAULT_unit));
    chk("t6_grant", 32'(grant_o),      32'd0);
    chk("t6_stall", 32'(unit_stall_o), 32'd0);
    #1 reset_n = 1'b1;
    model_clear();
    for (int c = 0; c < LIMIT; c++) begin
      drive(9'h041, 1'b0, 1'b0);
      chk("t6_fdiv_grant", 32'(obs_g), 32'h001);
    end
    drive(9'h041, 1'b0, 1'b0);
    chk("t6_promo", 32'(obs_g), 32'h040);

    // Random traffic; stalled units keep their valid asserted.
    for (int n = 0; n < 3000; n++) begin
      logic [8:0] v;
      v = 9'($urandom) | prev_stall;
      if ($urandom_range(0, 7) == 0) v = v & 9'($urandom);
      v = v | prev_stall;
      drive(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
